morse_decoder: RTL and testbench
================================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL provide parameter DOT_TICKS, default 1: mark length in ticks that is decoded as a dot.
REQ-002 SHALL provide parameter DASH_TICKS, default 3: mark length in ticks that is decoded as a dash.
REQ-003 SHALL provide parameter GAP_TICKS, default 3: space length in ticks that ends a letter.
REQ-004 SHALL provide port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port tick_en, input, 1 bit: one-cycle enable from the half-second divider; morse_in is sampled only in cycles where tick_en is high.
REQ-007 SHALL provide port morse_in, input, 1 bit: serial Morse line from the encoder stage (LEDR[0]); 1 = mark.
REQ-008 SHALL provide port letter_out, output, 3 bits: decoded letter, A=000 through H=111, matching the encoder's SW coding.
REQ-009 SHALL provide port letter_valid, output, 1 bit: one-cycle pulse when letter_out is updated.
REQ-010 SHALL provide port error, output, 1 bit: one-cycle pulse when a malformed letter is detected.

Function
REQ-011 SHALL implement states IDLE, MARK, SPACE and ERR.
- IDLE: a tick with morse_in=1 -> MARK, run counter = 1.
- MARK: a tick with morse_in=1 increments the run counter.
- MARK: a tick with morse_in=0 classifies the run (REQ-012), then -> SPACE with run counter = 1.
- SPACE: a tick with morse_in=0 increments the run counter.
- SPACE: a tick with morse_in=1 and space run = 1 -> MARK with run counter = 1.
REQ-012 Mark classification:
- run == DOT_TICKS: shift 0 into the symbol buffer.
- run == DASH_TICKS: shift 1 into the symbol buffer.
- any other run length: -> ERR.
REQ-013 In SPACE, a run reaching GAP_TICKS SHALL end the letter:
- the buffer (max 4 symbols, first symbol in the MSB position) and the symbol count are looked up against A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ....
- hit: latch letter_out and pulse letter_valid; miss: -> ERR behaviour.
- the state then returns to IDLE with the buffer cleared.
REQ-014 A mark that starts after a space run with 1 < run < GAP_TICKS SHALL send the block to ERR.
REQ-015 A fifth symbol in one letter SHALL send the block to ERR.
REQ-016 ERR SHALL pulse error once on entry, then ignore marks. It SHALL return to IDLE, with the buffer cleared, once a space run of GAP_TICKS completes. No letter_valid pulse is produced for the aborted letter.
REQ-017 Latency: letter_valid and error SHALL assert in the clock cycle immediately after the tick_en cycle that triggers them, for exactly one cycle.
REQ-018 letter_out SHALL hold its last decoded value between pulses.
REQ-019 Run counters SHALL be 3 bits wide and saturate at 7; they SHALL never wrap.
REQ-020 Cycles with tick_en low SHALL not change any state, counter or output, except that letter_valid and error deassert.

Reset
REQ-021 reset SHALL override all other inputs in the same cycle.
REQ-022 On reset:
- state = IDLE; buffer, symbol count and run counters = 0.
- letter_out = 000; letter_valid = 0; error = 0.
REQ-023 A reset mid-letter SHALL discard the partial letter with no pulse on letter_valid or error.

Configuration
REQ-024 Macro MORSE_DECODER_ERR_EN:
- defined: the error port is driven as specified.
- undefined: error is tied to 0. Malformed letters (REQ-012, REQ-014, REQ-015, lookup miss) are silently dropped through the same ERR recovery path, and letter_valid behaviour is unchanged.

Structure
REQ-025 A shared package SHALL hold:
- state encodings;
- letter codes A..H;
- Morse pattern and length constants;
- default tick-count constants, also used by the encoder.
REQ-026 The lookup SHALL be a sub-module morse_lut: inputs are the 4-bit pattern and 3-bit count; outputs are the 3-bit letter and a hit flag; purely combinational.

Verification
REQ-027 The bench SHALL use tick_en pulsing every 3 clocks and cover these directed scenarios (sequences are morse_in per tick):
- 1,0,1,1,1,0,0,0 -> one letter_valid pulse, letter_out = 000 (A), error never asserted.
- 1,1,1,0,1,0,1,0,1,0,0,0 -> letter_out = 001 (B), one pulse.
- 1,1,0,0,0 (2-tick mark) -> one error pulse, no letter_valid; a following A still decodes to 000.
- 1,0,1,0,1,0,1,0,1,0,0,0 (five dots) -> one error pulse on the fifth dot, no letter_valid.
- reset asserted after 1,0,1,1 -> all outputs 0 next cycle; a subsequent E (1,0,0,0) decodes to 100.
- morse_in held at 0 for 20 ticks after reset -> no letter_valid and no error pulses; letter_out stays 000.

Source files
------------

// File: rtl/morse_decoder_pkg.sv
// Shared Morse constants: FSM states, letter codes A..H, symbol patterns/lengths
// and default tick counts (also used by the encoder stage).
package morse_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Patterns are left-aligned: first symbol in bit 3, dash = 1, unused bits 0.
  localparam logic [3:0] PAT_A = 4'b0100;
  localparam logic [3:0] PAT_B = 4'b1000;
  localparam logic [3:0] PAT_C = 4'b1010;
  localparam logic [3:0] PAT_D = 4'b1000;
  localparam logic [3:0] PAT_E = 4'b0000;
  localparam logic [3:0] PAT_F = 4'b0010;
  localparam logic [3:0] PAT_G = 4'b1100;
  localparam logic [3:0] PAT_H = 4'b0000;

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

  localparam int MAX_SYMS       = 4;
  localparam int DEF_DOT_TICKS  = 1;
  localparam int DEF_DASH_TICKS = 3;
  localparam int DEF_GAP_TICKS  = 3;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Tick/line inputs and decoded-letter outputs of the Morse decoder.
interface morse_decoder_if;
  logic       tick_en;
  logic       morse_in;
  logic [2:0] letter_out;
  logic       letter_valid;
  logic       error;

  modport master (output tick_en, morse_in, input letter_out, letter_valid, error);
  modport slave  (input tick_en, morse_in, output letter_out, letter_valid, error);
endinterface

// File: rtl/morse_lut.sv
// Combinational pattern/length to letter lookup for A..H.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  logic [3:0] i_pattern,
  input  logic [2:0] i_count,
  output logic [2:0] o_letter,
  output logic       o_hit
);

  always_comb begin
    o_letter = LTR_A;
    o_hit    = 1'b0;
    if      (i_pattern == PAT_A && i_count == LEN_A) begin o_letter = LTR_A; o_hit = 1'b1; end
    else if (i_pattern == PAT_B && i_count == LEN_B) begin o_letter = LTR_B; o_hit = 1'b1; end
    else if (i_pattern == PAT_C && i_count == LEN_C) begin o_letter = LTR_C; o_hit = 1'b1; end
    else if (i_pattern == PAT_D && i_count == LEN_D) begin o_letter = LTR_D; o_hit = 1'b1; end
    else if (i_pattern == PAT_E && i_count == LEN_E) begin o_letter = LTR_E; o_hit = 1'b1; end
    else if (i_pattern == PAT_F && i_count == LEN_F) begin o_letter = LTR_F; o_hit = 1'b1; end
    else if (i_pattern == PAT_G && i_count == LEN_G) begin o_letter = LTR_G; o_hit = 1'b1; end
    else if (i_pattern == PAT_H && i_count == LEN_H) begin o_letter = LTR_H; o_hit = 1'b1; end
  end

endmodule

// File: rtl/morse_decoder.sv
// Tick-sampled Morse line decoder; letter_valid/error pulse one cycle after the triggering tick.
// MORSE_DECODER_ERR_EN defined drives the error pulse; otherwise error is tied low.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int DOT_TICKS  = DEF_DOT_TICKS,
  parameter int DASH_TICKS = DEF_DASH_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
  input logic           CLOCK_50,
  input logic           reset,
  morse_decoder_if.slave bus
);

`ifdef MORSE_DECODER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [2:0] DOT_R  = 3'(DOT_TICKS);
  localparam logic [2:0] DASH_R = 3'(DASH_TICKS);
  localparam logic [2:0] GAP_R  = 3'(GAP_TICKS);
  localparam logic [2:0] FULL_R = 3'(MAX_SYMS);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_run, w_run_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_sym_buf, w_buf_nxt;
  logic [2:0] r_letter, w_letter_nxt;
  logic       r_valid, r_error;
  logic       w_valid_evt, w_err_evt;
  logic [2:0] w_run_inc, w_lut_letter;
  logic       w_lut_hit, w_is_dot, w_is_dash, w_sym_ok, w_buf_full, w_gap_done;

  assign w_run_inc  = sat_inc(r_run);
  assign w_is_dot   = (r_run == DOT_R);
  assign w_is_dash  = (r_run == DASH_R);
  assign w_sym_ok   = w_is_dot || w_is_dash;
  assign w_buf_full = (r_cnt == FULL_R);
  assign w_gap_done = (w_run_inc == GAP_R);

  morse_lut u_lut (
    .i_pattern (r_sym_buf),
    .i_count   (r_cnt),
    .o_letter  (w_lut_letter),
    .o_hit     (w_lut_hit)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_cnt_nxt    = r_cnt;
    w_buf_nxt    = r_sym_buf;
    w_letter_nxt = r_letter;
    if (bus.tick_en) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.morse_in) begin
            w_state_nxt = ST_MARK;
            w_run_nxt   = 3'd1;
          end
        end
        ST_MARK: begin
          if (bus.morse_in) begin
            w_run_nxt = w_run_inc;
          end else begin
            // The closing space tick is the first tick of the following space run.
            w_run_nxt = 3'd1;
            if (!w_sym_ok || w_buf_full) begin
              w_state_nxt = ST_ERR;
            end else begin
              w_state_nxt = ST_SPACE;
              w_buf_nxt[~r_cnt[1:0]] = !w_is_dot;
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end
        end
        ST_SPACE: begin
          if (bus.morse_in) begin
            w_state_nxt = (r_run == 3'd1) ? ST_MARK : ST_ERR;
            w_run_nxt   = (r_run == 3'd1) ? 3'd1 : 3'd0;
          end else if (w_gap_done) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = 3'd0;
            w_cnt_nxt   = 3'd0;
            w_buf_nxt   = 4'b0000;
            if (w_lut_hit) w_letter_nxt = w_lut_letter;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end
        default: begin
          // ERR: marks restart the recovery space run; a full gap returns to IDLE.
          if (bus.morse_in) begin
            w_run_nxt = 3'd0;
          end else if (w_gap_done) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = 3'd0;
            w_cnt_nxt   = 3'd0;
            w_buf_nxt   = 4'b0000;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_valid_evt = 1'b0;
    w_err_evt   = 1'b0;
    if (bus.tick_en) begin
      case (r_state)
        ST_MARK:  w_err_evt = !bus.morse_in && (!w_sym_ok || w_buf_full);
        ST_SPACE: begin
          if (bus.morse_in) begin
            w_err_evt = (r_run != 3'd1);
          end else if (w_gap_done) begin
            w_valid_evt = w_lut_hit;
            w_err_evt   = !w_lut_hit;
          end
        end
        default: begin
          w_valid_evt = 1'b0;
          w_err_evt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_run     <= 3'd0;
      r_cnt     <= 3'd0;
      r_sym_buf <= 4'b0000;
      r_letter  <= LTR_A;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_run     <= w_run_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sym_buf <= w_buf_nxt;
      r_letter  <= w_letter_nxt;
      r_valid   <= w_valid_evt;
      r_error   <= w_err_evt & ERR_EN;
    end
  end

  assign bus.letter_out   = r_letter;
  assign bus.letter_valid = r_valid;
  assign bus.error        = r_error;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed and random Morse words checked against a run-length/lookup-table reference model.
module tb_morse_decoder;
  import morse_decoder_pkg::*;

`ifdef MORSE_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset;
  morse_decoder_if bus ();

  morse_decoder #(
    .DOT_TICKS  (DEF_DOT_TICKS),
    .DASH_TICKS (DEF_DASH_TICKS),
    .GAP_TICKS  (DEF_GAP_TICKS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  string morse_tab [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  bit seq [$];
  int exp_v_idx, exp_e_idx;
  int exp_letter = 0;
  int obs_v_idx, obs_v_cnt, obs_e_idx, obs_e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One tick period is three clocks; pulses are recorded against the tick index.
  task automatic tick(input bit b, input int idx);
    bus.morse_in = b;
    bus.tick_en  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk1();
      bus.tick_en = 1'b0;
      if (bus.letter_valid === 1'b1) begin
        obs_v_cnt++;
        if (obs_v_idx < 0) obs_v_idx = idx;
      end
      if (bus.error === 1'b1) begin
        obs_e_cnt++;
        if (obs_e_idx < 0) obs_e_idx = idx;
      end
    end
  endtask

  task automatic add_run(input bit b, input int n);
    for (int j = 0; j < n; j++) seq.push_back(b);
  endtask

  task automatic encode_letter(input int k);
    string s;
    s = morse_tab[k];
    for (int j = 0; j < s.len(); j++) begin
      if (j > 0) add_run(1'b0, 1);
      add_run(1'b1, (s[j] == "-") ? DEF_DASH_TICKS : DEF_DOT_TICKS);
    end
    add_run(1'b0, DEF_GAP_TICKS);
  endtask

  task automatic load(input logic [31:0] bits, input int n);
    seq.delete();
    for (int j = n - 1; j >= 0; j--) seq.push_back(bits[j]);
  endtask

  // Reference: split the word into mark/space runs and decode against the letter table.
  function automatic void model();
    int i, e, L, S, err;
    string syms;
    i = 0; err = -1; syms = ""; exp_v_idx = -1;
    while (i < seq.size() && !seq[i]) i++;
    while (i < seq.size()) begin
      L = 0;
      while (i + L < seq.size() && seq[i + L]) L++;
      e = i + L;
      if (!(L == DEF_DOT_TICKS || L == DEF_DASH_TICKS) || syms.len() == MAX_SYMS) begin
        err = e;
        break;
      end
      if (L == DEF_DOT_TICKS) syms = {syms, "."};
      else                    syms = {syms, "-"};
      S = 0;
      while (e + S < seq.size() && !seq[e + S]) S++;
      if (S >= DEF_GAP_TICKS) begin
        err = e + DEF_GAP_TICKS - 1;
        for (int k = 0; k < 8; k++) begin
          if (syms == morse_tab[k]) begin
            exp_v_idx  = err;
            exp_letter = k;
            err        = -1;
          end
        end
        break;
      end else if (S > 1) begin
        err = e + S;
        break;
      end
      i = e + 1;
    end
    exp_e_idx = ERR_EN ? err : -1;
  endfunction

  task automatic run_word(input string tag);
    model();
    obs_v_idx = -1; obs_v_cnt = 0; obs_e_idx = -1; obs_e_cnt = 0;
    for (int k = 0; k < seq.size(); k++) tick(seq[k], k);
    check({tag, "/valid_at"},  obs_v_idx, exp_v_idx);
    check({tag, "/valid_cnt"}, obs_v_cnt, (exp_v_idx >= 0) ? 1 : 0);
    check({tag, "/err_at"},    obs_e_idx, exp_e_idx);
    check({tag, "/err_cnt"},   obs_e_cnt, (exp_e_idx >= 0) ? 1 : 0);
    check({tag, "/letter"},    32'(bus.letter_out), exp_letter);
  endtask

  task automatic random_word();
    int n, L;
    seq.delete();
    add_run(1'b0, $urandom_range(0, 3));
    if ($urandom_range(0, 9) < 6) begin
      encode_letter($urandom_range(0, 7));
    end else begin
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        if (j > 0) add_run(1'b0, ($urandom_range(0, 11) == 0) ? 2 : 1);
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 2))
            0:       L = 2;
            1:       L = 4;
            default: L = 9;
          endcase
        end else begin
          L = $urandom_range(0, 1) ? DEF_DOT_TICKS : DEF_DASH_TICKS;
        end
        add_run(1'b1, L);
      end
      add_run(1'b0, DEF_GAP_TICKS);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.tick_en  = 1'b0;
    bus.morse_in = 1'b0;
    repeat (3) clk1();
    check("reset/letter", 32'(bus.letter_out), 0);
    check("reset/valid",  32'(bus.letter_valid), 0);
    check("reset/error",  32'(bus.error), 0);
    reset = 1'b0;
    clk1();

    seq.delete();
    add_run(1'b0, 20);
    run_word("idle20");

    load(32'b10111000, 8);            run_word("A");
    check("A/const_letter", 32'(bus.letter_out), 0);
    check("A/no_error", obs_e_cnt, 0);
    load(32'b111010101000, 12);       run_word("B");
    check("B/const_letter", 32'(bus.letter_out), 1);
    load(32'b11000, 5);               run_word("mark2");
    load(32'b10111000, 8);            run_word("A_after_err");
    check("A2/const_letter", 32'(bus.letter_out), 0);
    load(32'b101010101000, 12);       run_word("five_dots");
    check("five_dots/err_tick", obs_e_idx, ERR_EN ? 9 : -1);
    load(32'b1111111111000, 13);      run_word("mark10_sat");
    load(32'b1001000, 7);             run_word("space2");
    load(32'b1110111000, 10);         run_word("miss_dashdash");
    load(32'b1110101000, 10);         run_word("D");

    // Partial letter, then reset coinciding with a mark tick.
    load(32'b1011, 4);
    obs_v_cnt = 0; obs_e_cnt = 0; obs_v_idx = -1; obs_e_idx = -1;
    for (int k = 0; k < seq.size(); k++) tick(seq[k], k);
    reset = 1'b1;
    bus.tick_en  = 1'b1;
    bus.morse_in = 1'b1;
    clk1();
    reset = 1'b0;
    bus.tick_en  = 1'b0;
    bus.morse_in = 1'b0;
    check("rst_mid/letter", 32'(bus.letter_out), 0);
    check("rst_mid/valid",  32'(bus.letter_valid), 0);
    check("rst_mid/error",  32'(bus.error), 0);
    check("rst_mid/no_pulses", obs_v_cnt + obs_e_cnt, 0);
    exp_letter = 0;
    clk1();
    load(32'b1000, 4);                run_word("E_after_rst");
    check("E/const_letter", 32'(bus.letter_out), 4);

    for (int w = 0; w < 40; w++) begin
      random_word();
      run_word($sformatf("rand%0d", w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
